// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, valid/ready handshake.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [2:0]      status
);

  typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} state_e;

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  state_e              r_state, w_state_d;
  logic [2:0]          r_op, w_op_d;
  logic                r_neg, w_neg_d;
  logic                r_special, w_special_d;
  logic                r_ovf, w_ovf_d;
  logic [XLEN-1:0]     r_spec_res, w_spec_res_d;
  logic [XLEN-1:0]     r_ma, w_ma_d;
  logic [XLEN-1:0]     r_mb, w_mb_d;
  logic [2*XLEN-1:0]   r_acc, w_acc_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic [XLEN-1:0]     r_result, w_result_d;
  logic [2:0]          r_status, w_status_d;

  logic                w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_div0, w_ovf;
  logic [XLEN-1:0]     w_ma, w_mb, w_spec_res;
  logic [2*XLEN-1:0]   w_mul_acc, w_div_acc, w_prod;
  logic [XLEN:0]       w_trial;
  logic [XLEN-1:0]     w_quo, w_rem, w_res;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     w_fa, w_fb;
  logic signed [2*XLEN-1:0] w_fast_prod;

  always_comb begin
    w_fa        = {w_a_sgn & a[XLEN-1], a};
    w_fb        = {w_b_sgn & b[XLEN-1], b};
    w_fast_prod = (2*XLEN)'(w_fa) * (2*XLEN)'(w_fb);
  end
`endif

  // Operand decode, magnitudes and accept-time special cases.
  always_comb begin
    w_a_sgn = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
              (funct3 == 3'b110);
    w_b_sgn = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    w_a_neg = w_a_sgn & a[XLEN-1];
    w_b_neg = w_b_sgn & b[XLEN-1];
    w_ma    = w_a_neg ? -a : a;
    w_mb    = w_b_neg ? -b : b;
    w_div0  = funct3[2] && (b == '0);
    w_ovf   = funct3[2] && !funct3[0] && (a == MinNeg) && (b == '1);
    if (w_div0) w_spec_res = funct3[1] ? a : '1;
    else        w_spec_res = funct3[1] ? '0 : a;
  end

  // Accumulator holds {remainder, quotient} for divide, the product for multiply.
  always_comb begin
    w_mul_acc = {r_acc[2*XLEN-2:0], 1'b0} + (r_mb[XLEN-1] ? {{XLEN{1'b0}}, r_ma} : '0);
    w_trial   = {r_acc[2*XLEN-1:XLEN], r_ma[XLEN-1]} - {1'b0, r_mb};
    if (!w_trial[XLEN]) w_div_acc = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    else w_div_acc = {r_acc[2*XLEN-2:XLEN], r_ma[XLEN-1], r_acc[XLEN-2:0], 1'b0};
  end

  always_comb begin
    w_prod = r_neg ? -r_acc : r_acc;
    w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem  = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    if (r_special)              w_res = r_spec_res;
    else if (r_op[2])           w_res = r_op[1] ? w_rem : w_quo;
    else if (r_op[1:0] == 2'b00) w_res = w_prod[XLEN-1:0];
    else                        w_res = w_prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    w_state_d    = r_state;
    w_op_d       = r_op;
    w_neg_d      = r_neg;
    w_special_d  = r_special;
    w_ovf_d      = r_ovf;
    w_spec_res_d = r_spec_res;
    w_ma_d       = r_ma;
    w_mb_d       = r_mb;
    w_acc_d      = r_acc;
    w_cnt_d      = r_cnt;
    w_result_d   = r_result;
    w_status_d   = r_status;
    unique case (r_state)
      StIdle: begin
        if (in_valid && !flush) begin
          w_op_d       = funct3;
          w_neg_d      = (funct3[2] && funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
          w_special_d  = w_div0 || w_ovf;
          w_ovf_d      = w_ovf;
          w_spec_res_d = w_spec_res;
          w_ma_d       = w_ma;
          w_mb_d       = w_mb;
          w_acc_d      = '0;
          w_cnt_d      = CNT_W'(XLEN);
          w_state_d    = (w_div0 || w_ovf) ? StFixup : StCalc;
`ifdef MULDIV_FAST_MUL_EN
          if (!funct3[2]) begin
            w_acc_d   = w_fast_prod;
            w_neg_d   = 1'b0;
            w_state_d = StFixup;
          end
`endif
        end
      end
      StCalc: begin
        w_cnt_d = r_cnt - CNT_W'(1);
        if (r_op[2]) begin
          w_acc_d = w_div_acc;
          w_ma_d  = r_ma << 1;
        end else begin
          w_acc_d = w_mul_acc;
          w_mb_d  = r_mb << 1;
        end
        if (r_cnt == CNT_W'(1)) w_state_d = StFixup;
      end
      StFixup: begin
        w_result_d = w_res;
        w_status_d = {w_res[XLEN-1], r_ovf, w_res == '0};
        w_state_d  = StDone;
      end
      StDone: begin
        if (out_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
    // A flush abandons everything, including a result about to be registered.
    if (flush) begin
      w_state_d  = StIdle;
      w_result_d = r_result;
      w_status_d = r_status;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_op       <= '0;
      r_neg      <= 1'b0;
      r_special  <= 1'b0;
      r_ovf      <= 1'b0;
      r_spec_res <= '0;
      r_ma       <= '0;
      r_mb       <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_status   <= 3'b001;
    end else begin
      r_state    <= w_state_d;
      r_op       <= w_op_d;
      r_neg      <= w_neg_d;
      r_special  <= w_special_d;
      r_ovf      <= w_ovf_d;
      r_spec_res <= w_spec_res_d;
      r_ma       <= w_ma_d;
      r_mb       <= w_mb_d;
      r_acc      <= w_acc_d;
      r_cnt      <= w_cnt_d;
      r_result   <= w_result_d;
      r_status   <= w_status_d;
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign result    = r_result;
  assign status    = r_status;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, random operations against an
// arithmetic reference model, handshake hold, flush and asynchronous reset behaviour.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [2:0]      status;

  int vectors;
  int miscompares;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the RV32M rules.
  task automatic model(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] r, output logic [2:0] st, output int lat);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    logic            ovf;
    logic            special;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    ua  = {32'b0, av};
    ub  = {32'b0, bv};
    ovf = 1'b0;
    r   = '0;
    case (f)
      3'b000: begin p = sa * sb; r = p[31:0]; end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * longint'(ub); r = p[63:32]; end
      3'b011: begin up = ua * ub; r = up[63:32]; end
      3'b100: begin
        if (bv == 0) r = '1;
        else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin r = av; ovf = 1'b1; end
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'b101: begin
        if (bv == 0) r = '1;
        else begin up = ua / ub; r = up[31:0]; end
      end
      3'b110: begin
        if (bv == 0) r = av;
        else if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin r = '0; ovf = 1'b1; end
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (bv == 0) r = av;
        else begin up = ua % ub; r = up[31:0]; end
      end
    endcase
    st      = {r[31], ovf, r == 0};
    special = f[2] && (bv == 0 || ovf);
    // Edges after the accept edge until out_valid is visible.
    lat = special ? 1 : XLEN + 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!f[2]) lat = 1;
`endif
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                       input logic [31:0] bv, input int hold);
    logic [31:0] er;
    logic [2:0]  es;
    int          elat;
    int          lat;
    model(f, av, bv, er, es, elat);
    check({tag, " in_ready before accept"}, in_ready, 1'b1);
    in_valid = 1'b1;
    funct3   = f;
    a        = av;
    b        = bv;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      a      = $urandom;
      b      = $urandom;
      funct3 = 3'($urandom);
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " result"}, result, er);
    check({tag, " status"}, status, es);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " held result"}, result, er);
      check({tag, " held out_valid"}, out_valid, 1'b1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    check({tag, " in_ready in consume cycle"}, in_ready, 1'b0);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, " out_valid after consume"}, out_valid, 1'b0);
    check({tag, " in_ready after consume"}, in_ready, 1'b1);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    funct3    = '0;
    a         = '0;
    b         = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("reset out_valid", out_valid, 1'b0);
    check("reset result", result, 32'h0);
    check("reset status", status, 3'b001);
    rst_n = 1'b1;
    #1;
    check("in_ready after reset release", in_ready, 1'b1);
    tick();

    do_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5);
    do_op("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 0);
    do_op("MULHSU -1*ffffffff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("MULHU ffffffff^2", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 1);
    do_op("REM -7%2", 3'b110, 32'hFFFF_FFF9, 32'd2, 0);
    do_op("DIVU 5/0", 3'b101, 32'd5, 32'd0, 0);
    do_op("REMU 5%0", 3'b111, 32'd5, 32'd0, 0);
    do_op("DIV min/-1", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("REM min%-1", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op("DIV 7/0", 3'b100, 32'd7, 32'd0, 0);
    do_op("DIVU big", 3'b101, 32'hFFFF_FFFF, 32'd3, 0);

    for (int n = 0; n < 40; n++) begin
      do_op("random", 3'($urandom), rnd_operand(), rnd_operand(), $urandom_range(0, 2));
    end

    // Flush mid-calculation with a competing request: nothing accepted, nothing produced.
    in_valid = 1'b1;
    funct3   = 3'b100;
    a        = 32'd1000;
    b        = 32'd7;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush    = 1'b1;
    in_valid = 1'b1;
    funct3   = 3'b000;
    a        = $urandom;
    b        = $urandom;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush returns to idle", in_ready, 1'b1);
    check("flush out_valid", out_valid, 1'b0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("no out_valid after flush", seen, 0);
    check("still idle after flush", in_ready, 1'b1);

    // Flush while a result is waiting discards it.
    do_op("MUL 6*7", 3'b000, 32'd6, 32'd7, 0);
    in_valid = 1'b1;
    funct3   = 3'b101;
    a        = 32'd9;
    b        = 32'd0;
    tick();
    in_valid = 1'b0;
    tick();
    check("special reaches done", out_valid, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush in done drops out_valid", out_valid, 1'b0);
    check("flush in done idle", in_ready, 1'b1);

    // Asynchronous reset mid-operation.
    do_op("MUL before reset", 3'b000, 32'd7, 32'hFFFF_FFFD, 0);
    in_valid = 1'b1;
    funct3   = 3'b100;
    a        = 32'd12345;
    b        = 32'd11;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset in_ready", in_ready, 1'b1);
    check("async reset out_valid", out_valid, 1'b0);
    check("async reset result", result, 32'h0);
    check("async reset status", status, 3'b001);
    tick();
    rst_n = 1'b1;
    tick();
    do_op("DIV after reset", 3'b100, 32'd100, 32'hFFFF_FFF9, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
